npu_dbg_arbiter: RTL and testbench
==================================

NPU_DBG_ARBITER -- requirements
Module: npu_dbg_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of every address bus.
REQ-002 Parameter DATA_WIDTH, default 32, width of every data bus.
REQ-003 Parameter TIMEOUT_CYCLES, default 256, target-ack wait limit in clk cycles; legal range 2..65535.
REQ-004 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 npu_halted  input  1  NPU halted; gives the debug requester fixed priority.
REQ-008 host_req / host_we  input  1 / 1  host request (level) and write flag.
REQ-009 host_addr / host_wdata  input  ADDR_WIDTH / DATA_WIDTH  host command.
REQ-010 host_gnt / host_rsp_valid / host_err  output  1 / 1 / 1  host grant pulse, response pulse, error flag.
REQ-011 host_rdata  output  DATA_WIDTH  host read data.
REQ-012 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_rsp_valid, dbg_rdata, dbg_err  SHALL mirror REQ-008..011 for the JTAG debug requester.
REQ-013 tgt_req / tgt_we  output  1 / 1  target bus request (level) and write flag.
REQ-014 tgt_addr / tgt_wdata  output  ADDR_WIDTH / DATA_WIDTH  target command.
REQ-015 tgt_rdata  input  DATA_WIDTH; tgt_ack / tgt_err  input  1 / 1  target read data, completion, error.
REQ-016 tgt_timeout  output  1  one-cycle pulse when a target access times out.

Function
REQ-017 FSM states: ARB_IDLE, ARB_BUSY, ARB_RESP; only one transaction is outstanding at any time.
REQ-018 In ARB_IDLE with any requester asserted, the block SHALL select a winner, latch its we/addr/wdata, pulse the winner's gnt for one cycle, and enter ARB_BUSY.
REQ-019 Arbitration: npu_halted=1 -> debug wins; otherwise round-robin, with the requester not granted last winning a tie.
REQ-020 In ARB_BUSY, tgt_req=1 with tgt_we/tgt_addr/tgt_wdata held stable from the latched command until exit.
REQ-021 In ARB_BUSY, tgt_ack=1 -> capture tgt_rdata (0 for writes), set error = tgt_err, enter ARB_RESP.
REQ-022 tgt_ack and tgt_err in the same cycle SHALL produce an error response.
REQ-023 A wait counter SHALL clear on entry to ARB_BUSY; when it reaches TIMEOUT_CYCLES-1 without ack, tgt_timeout pulses, error=1, rdata=0, and the FSM enters ARB_RESP.
REQ-024 In ARB_RESP, tgt_req=0 and the owner's rsp_valid pulses for one cycle with rdata/err valid; the FSM then returns to ARB_IDLE.
REQ-025 Latency: gnt in cycle N, tgt_req first high in N+1, ack in cycle M, rsp_valid in M+1; minimum request-to-response time is 3 cycles.
REQ-026 tgt_ack or tgt_err outside ARB_BUSY SHALL be ignored.
REQ-027 rdata/err outputs SHALL hold their last value; only rsp_valid qualifies them. The non-owner's rsp_valid and gnt remain 0.
REQ-028 A requester deasserting req before gnt SHALL simply not be served; req after gnt is ignored until the next ARB_IDLE.

Reset
REQ-029 While rst_n=0, all outputs SHALL be 0, the FSM SHALL be in ARB_IDLE, and the wait counter SHALL be 0.
REQ-030 The round-robin pointer SHALL reset to "host granted last", so debug wins the first tie.
REQ-031 Reset mid-transaction SHALL drop the transaction silently, with no rsp_valid after release.

Structure
REQ-032 npu_pkg SHALL hold dbg_arb_state_t (the three states), dbg_arb_owner_t (ARB_OWN_HOST, ARB_OWN_DBG), and localparam DBG_ARB_TIMEOUT_DEF=256.
REQ-033 One sub-module, npu_rr_arb2 (2-way round-robin with a priority-override input), is natural; the FSM, counter, and muxing stay in the top level.

Verification
REQ-034 Host read only, target ack 2 cycles after tgt_req with tgt_rdata=0x1234_5678 -> host_gnt, then host_rsp_valid with host_rdata=0x1234_5678, host_err=0.
REQ-035 Both requests held, npu_halted=0, four transactions -> grant order dbg, host, dbg, host.
REQ-036 Both requests held, npu_halted=1 -> dbg granted every time; host starves.
REQ-037 TIMEOUT_CYCLES=16, no ack -> tgt_timeout pulse 16 cycles after tgt_req rises, err=1, rdata=0, FSM back to ARB_IDLE.
REQ-038 Debug write addr=0x40 data=0xA5A5_A5A5 with tgt_ack and tgt_err together -> dbg_err=1, dbg_rdata=0.
REQ-039 rst_n asserted mid-ARB_BUSY -> tgt_req=0 immediately, no rsp_valid after release, next tie granted to dbg.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared types for the NPU debug/host target-bus arbiter.
package npu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } dbg_arb_state_t;

    typedef enum logic {
        ARB_OWN_HOST = 1'b0,
        ARB_OWN_DBG  = 1'b1
    } dbg_arb_owner_t;

    localparam int DBG_ARB_TIMEOUT_DEF = 256;

    // Debug wins when forced or when host was served last; a lone requester always wins.
    function automatic dbg_arb_owner_t rr_pick(input logic req_host, input logic req_dbg,
                                               input logic force_dbg, input dbg_arb_owner_t last);
        if (req_dbg && (!req_host || force_dbg || last == ARB_OWN_HOST))
            return ARB_OWN_DBG;
        return ARB_OWN_HOST;
    endfunction

endpackage

// File: rtl/npu_dbg_arbiter_if.sv
// Host/debug requester ports plus the shared target bus of the debug arbiter.
interface npu_dbg_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  npu_halted;

    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_gnt;
    logic                  host_rsp_valid;
    logic                  host_err;
    logic [DATA_WIDTH-1:0] host_rdata;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_gnt;
    logic                  dbg_rsp_valid;
    logic                  dbg_err;
    logic [DATA_WIDTH-1:0] dbg_rdata;

    logic                  tgt_req;
    logic                  tgt_we;
    logic [ADDR_WIDTH-1:0] tgt_addr;
    logic [DATA_WIDTH-1:0] tgt_wdata;
    logic [DATA_WIDTH-1:0] tgt_rdata;
    logic                  tgt_ack;
    logic                  tgt_err;
    logic                  tgt_timeout;

    // Arbiter side.
    modport slave (
        input  npu_halted,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rsp_valid, host_err, host_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rsp_valid, dbg_err, dbg_rdata,
        output tgt_req, tgt_we, tgt_addr, tgt_wdata, tgt_timeout,
        input  tgt_rdata, tgt_ack, tgt_err
    );

    // Environment side: requesters and target.
    modport master (
        output npu_halted,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rsp_valid, host_err, host_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rsp_valid, dbg_err, dbg_rdata,
        input  tgt_req, tgt_we, tgt_addr, tgt_wdata, tgt_timeout,
        output tgt_rdata, tgt_ack, tgt_err
    );
endinterface

// File: rtl/npu_rr_arb2.sv
// Two-way round-robin arbiter with a debug-priority override.
module npu_rr_arb2
    import npu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req_host,
    input  logic           req_dbg,
    input  logic           force_dbg,
    input  logic           take,
    output logic           win_valid,
    output dbg_arb_owner_t win_owner
);
    dbg_arb_owner_t last_q, last_d;

    always_comb begin
        win_valid = req_host | req_dbg;
        win_owner = rr_pick(req_host, req_dbg, force_dbg, last_q);
        last_d    = last_q;
        if (take && win_valid)
            last_d = win_owner;
    end

    // Reset to "host served last" so debug takes the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_q <= ARB_OWN_HOST;
        else
            last_q <= last_d;
    end
endmodule

// File: rtl/npu_dbg_arbiter.sv
// Arbitrates host and JTAG debug accesses onto one target bus, one transaction at a time.
module npu_dbg_arbiter
    import npu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DBG_ARB_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    npu_dbg_arbiter_if.slave   bus
);
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dbg_arb_state_t        state_q, state_d;
    dbg_arb_owner_t        owner_q, owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  tgt_req_q, tgt_req_d;
    logic                  tgt_timeout_q, tgt_timeout_d;
    logic                  host_gnt_q, host_gnt_d;
    logic                  dbg_gnt_q, dbg_gnt_d;
    logic                  host_rsp_valid_q, host_rsp_valid_d;
    logic                  dbg_rsp_valid_q, dbg_rsp_valid_d;
    logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic [DATA_WIDTH-1:0] dbg_rdata_q, dbg_rdata_d;
    logic                  host_err_q, host_err_d;
    logic                  dbg_err_q, dbg_err_d;

    logic                  win_valid;
    dbg_arb_owner_t        win_owner;
    logic                  take;
    logic                  rsp_fire;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    npu_rr_arb2 u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_host  (bus.host_req),
        .req_dbg   (bus.dbg_req),
        .force_dbg (bus.npu_halted),
        .take      (take),
        .win_valid (win_valid),
        .win_owner (win_owner)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        tgt_req_d     = 1'b0;
        tgt_timeout_d = 1'b0;
        host_gnt_d    = 1'b0;
        dbg_gnt_d     = 1'b0;
        take          = 1'b0;
        rsp_fire      = 1'b0;
        rsp_rdata     = '0;
        rsp_err       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (win_valid) begin
                    take    = 1'b1;
                    owner_d = win_owner;
                    cnt_d   = '0;
                    state_d = ARB_BUSY;
                    if (win_owner == ARB_OWN_DBG) begin
                        we_d      = bus.dbg_we;
                        addr_d    = bus.dbg_addr;
                        wdata_d   = bus.dbg_wdata;
                        dbg_gnt_d = 1'b1;
                    end else begin
                        we_d       = bus.host_we;
                        addr_d     = bus.host_addr;
                        wdata_d    = bus.host_wdata;
                        host_gnt_d = 1'b1;
                    end
                end
            end
            ARB_BUSY: begin
                tgt_req_d = 1'b1;
                // The first BUSY cycle is the grant cycle; the target is only listened to once tgt_req is up.
                if (tgt_req_q && bus.tgt_ack) begin
                    rsp_fire  = 1'b1;
                    rsp_rdata = we_q ? '0 : bus.tgt_rdata;
                    rsp_err   = bus.tgt_err;
                end else if (tgt_req_q && cnt_q == CNT_LAST) begin
                    rsp_fire      = 1'b1;
                    rsp_err       = 1'b1;
                    tgt_timeout_d = 1'b1;
                end else if (tgt_req_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (rsp_fire) begin
                    tgt_req_d = 1'b0;
                    state_d   = ARB_RESP;
                end
            end
            ARB_RESP: begin
                cnt_d   = '0;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Response fields of the idle requester keep their previous values.
    always_comb begin
        host_rsp_valid_d = rsp_fire && (owner_q == ARB_OWN_HOST);
        dbg_rsp_valid_d  = rsp_fire && (owner_q == ARB_OWN_DBG);
        host_rdata_d     = host_rsp_valid_d ? rsp_rdata : host_rdata_q;
        host_err_d       = host_rsp_valid_d ? rsp_err   : host_err_q;
        dbg_rdata_d      = dbg_rsp_valid_d  ? rsp_rdata : dbg_rdata_q;
        dbg_err_d        = dbg_rsp_valid_d  ? rsp_err   : dbg_err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ARB_IDLE;
            owner_q          <= ARB_OWN_HOST;
            cnt_q            <= '0;
            we_q             <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            tgt_req_q        <= 1'b0;
            tgt_timeout_q    <= 1'b0;
            host_gnt_q       <= 1'b0;
            dbg_gnt_q        <= 1'b0;
            host_rsp_valid_q <= 1'b0;
            dbg_rsp_valid_q  <= 1'b0;
            host_rdata_q     <= '0;
            dbg_rdata_q      <= '0;
            host_err_q       <= 1'b0;
            dbg_err_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            cnt_q            <= cnt_d;
            we_q             <= we_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            tgt_req_q        <= tgt_req_d;
            tgt_timeout_q    <= tgt_timeout_d;
            host_gnt_q       <= host_gnt_d;
            dbg_gnt_q        <= dbg_gnt_d;
            host_rsp_valid_q <= host_rsp_valid_d;
            dbg_rsp_valid_q  <= dbg_rsp_valid_d;
            host_rdata_q     <= host_rdata_d;
            dbg_rdata_q      <= dbg_rdata_d;
            host_err_q       <= host_err_d;
            dbg_err_q        <= dbg_err_d;
        end
    end

    assign bus.host_gnt       = host_gnt_q;
    assign bus.dbg_gnt        = dbg_gnt_q;
    assign bus.host_rsp_valid = host_rsp_valid_q;
    assign bus.dbg_rsp_valid  = dbg_rsp_valid_q;
    assign bus.host_rdata     = host_rdata_q;
    assign bus.dbg_rdata      = dbg_rdata_q;
    assign bus.host_err       = host_err_q;
    assign bus.dbg_err        = dbg_err_q;
    assign bus.tgt_req        = tgt_req_q;
    assign bus.tgt_we         = we_q;
    assign bus.tgt_addr       = addr_q;
    assign bus.tgt_wdata      = wdata_q;
    assign bus.tgt_timeout    = tgt_timeout_q;
endmodule

// File: tb/tb_npu_dbg_arbiter.sv
// Bench for npu_dbg_arbiter: directed vector table, reset corner cases, randomized transactions.
module tb_npu_dbg_arbiter;
    import npu_pkg::*;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    npu_dbg_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    npu_dbg_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic           hreq, dreq, halted, hwe, dwe;
        logic [31:0]    haddr, hwd, daddr, dwd;
        int             delay;   // cycles after tgt_req rises; >= TO means never ack
        logic [31:0]    trd;
        logic           terr;
        dbg_arb_owner_t exp_own;
        logic [31:0]    exp_rd;
        logic           exp_err, exp_to;
    } vec_t;

    int errors = 0;
    int checks = 0;
    logic [31:0] host_rd_m, dbg_rd_m;
    logic        host_err_m, dbg_err_m;
    dbg_arb_owner_t last_m;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.npu_halted = 1'b0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
        bus.dbg_req  = 1'b0; bus.dbg_we  = 1'b0; bus.dbg_addr  = '0; bus.dbg_wdata  = '0;
        bus.tgt_rdata = '0; bus.tgt_ack = 1'b0; bus.tgt_err = 1'b0;
    endtask

    task automatic reset_model();
        host_rd_m = '0; dbg_rd_m = '0; host_err_m = 1'b0; dbg_err_m = 1'b0;
        last_m = ARB_OWN_HOST;
    endtask

    function automatic logic [15:0] all_outs();
        return {bus.host_gnt, bus.dbg_gnt, bus.host_rsp_valid, bus.dbg_rsp_valid,
                bus.host_err, bus.dbg_err, bus.tgt_req, bus.tgt_we, bus.tgt_timeout, 7'd0};
    endfunction

    // One complete transaction starting from ARB_IDLE; checks grant, target command, response.
    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] ea, ew;
        logic        ewe, bad, own_h;
        int          resp_c;
        own_h = (v.exp_own == ARB_OWN_HOST);
        ea  = own_h ? v.haddr : v.daddr;
        ew  = own_h ? v.hwd   : v.dwd;
        ewe = own_h ? v.hwe   : v.dwe;
        bus.npu_halted = v.halted;
        bus.host_req = v.hreq; bus.host_we = v.hwe; bus.host_addr = v.haddr; bus.host_wdata = v.hwd;
        bus.dbg_req  = v.dreq; bus.dbg_we  = v.dwe; bus.dbg_addr  = v.daddr; bus.dbg_wdata  = v.dwd;
        step();
        chk({tag, " gnt{host,dbg}"}, {30'd0, bus.host_gnt, bus.dbg_gnt}, {30'd0, own_h, !own_h});
        chk({tag, " tgt_req in gnt cycle"}, {31'd0, bus.tgt_req}, 32'd0);
        step();
        chk({tag, " tgt_req"}, {31'd0, bus.tgt_req}, 32'd1);
        chk({tag, " tgt_we"}, {31'd0, bus.tgt_we}, {31'd0, ewe});
        chk({tag, " tgt_addr"}, bus.tgt_addr, ea);
        chk({tag, " tgt_wdata"}, bus.tgt_wdata, ew);
        resp_c = (v.delay < TO) ? v.delay + 1 : TO;
        bad = 1'b0;
        for (int c = 0; c < resp_c; c++) begin
            bad |= (bus.tgt_req !== 1'b1) | (bus.tgt_addr !== ea) | (bus.tgt_wdata !== ew)
                 | (bus.host_rsp_valid !== 1'b0) | (bus.dbg_rsp_valid !== 1'b0)
                 | (bus.host_gnt !== 1'b0) | (bus.dbg_gnt !== 1'b0) | (bus.tgt_timeout !== 1'b0);
            if (c == v.delay) begin
                bus.tgt_ack = 1'b1; bus.tgt_rdata = v.trd; bus.tgt_err = v.terr;
            end else begin
                bus.tgt_ack = 1'b0; bus.tgt_rdata = $urandom; bus.tgt_err = 1'b0;
            end
            step();
        end
        bus.tgt_ack = 1'b0; bus.tgt_err = 1'b0;
        bus.host_req = 1'b0; bus.dbg_req = 1'b0;
        chk({tag, " busy phase stable"}, {31'd0, bad}, 32'd0);
        if (own_h) begin host_rd_m = v.exp_rd; host_err_m = v.exp_err; end
        else       begin dbg_rd_m  = v.exp_rd; dbg_err_m  = v.exp_err; end
        chk({tag, " rsp_valid{host,dbg}"}, {30'd0, bus.host_rsp_valid, bus.dbg_rsp_valid},
            {30'd0, own_h, !own_h});
        chk({tag, " host_rdata"}, bus.host_rdata, host_rd_m);
        chk({tag, " dbg_rdata"}, bus.dbg_rdata, dbg_rd_m);
        chk({tag, " err{host,dbg}"}, {30'd0, bus.host_err, bus.dbg_err}, {30'd0, host_err_m, dbg_err_m});
        chk({tag, " tgt_timeout"}, {31'd0, bus.tgt_timeout}, {31'd0, v.exp_to});
        chk({tag, " tgt_req in resp"}, {31'd0, bus.tgt_req}, 32'd0);
        step();
        chk({tag, " pulses cleared"}, {28'd0, bus.host_rsp_valid, bus.dbg_rsp_valid, bus.tgt_timeout,
            bus.tgt_req}, 32'd0);
        last_m = v.exp_own;
    endtask

    initial begin
        vec_t v;
        logic bad;
        int   r;

        //        hreq dreq hlt hwe dwe haddr         hwd            daddr         dwd            dly trd            terr own           exp_rd         err  to
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_0100,32'h0,        32'h0000_0200,32'h0,        2,  32'h1234_5678,1'b0,ARB_OWN_HOST,32'h1234_5678,1'b0,1'b0};
        tbl[1]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,32'h0000_0104,32'h1111_1111,32'h0000_0204,32'h0,        1,  32'hDEAD_0001,1'b0,ARB_OWN_DBG, 32'hDEAD_0001,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b1,1'b0,1'b0,1'b1,32'h0000_0108,32'h0,        32'h0000_0208,32'h2222_2222,0,  32'hBEEF_0002,1'b0,ARB_OWN_HOST,32'hBEEF_0002,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,1'b0,1'b1,1'b1,32'h0000_010C,32'h3333_3333,32'h0000_020C,32'h4444_4444,4,  32'h5555_AAAA,1'b0,ARB_OWN_DBG, 32'h0,        1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_0110,32'h0,        32'h0000_0210,32'h0,        3,  32'h0BAD_F00D,1'b0,ARB_OWN_HOST,32'h0BAD_F00D,1'b0,1'b0};
        tbl[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0000_0114,32'h0,        32'h0000_0214,32'h0,        1,  32'h600D_CAFE,1'b0,ARB_OWN_DBG, 32'h600D_CAFE,1'b0,1'b0};
        tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0000_0118,32'h0,        32'h0000_0218,32'h0,        2,  32'h7777_7777,1'b0,ARB_OWN_DBG, 32'h7777_7777,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,32'h0,        32'h0,        32'h0000_0040,32'hA5A5_A5A5,0,  32'h9999_9999,1'b1,ARB_OWN_DBG, 32'h0,        1'b1,1'b0};
        tbl[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0000_0300,32'h0,        32'h0,        32'h0,        99, 32'h1212_1212,1'b0,ARB_OWN_HOST,32'h0,        1'b1,1'b1};
        tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,        32'h0,        32'h0000_0304,32'h0,        15, 32'hCAFE_F00D,1'b0,ARB_OWN_DBG, 32'hCAFE_F00D,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b0,1'b0,1'b1,1'b0,32'h0000_0308,32'h1357_9BDF,32'h0,        32'h0,        5,  32'hFFFF_FFFF,1'b0,ARB_OWN_HOST,32'h0,        1'b0,1'b0};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0000_030C,32'h0,        32'h0,        32'h0,        1,  32'h2468_ACE0,1'b0,ARB_OWN_HOST,32'h2468_ACE0,1'b0,1'b0};

        idle_inputs();
        reset_model();
        bus.host_req = 1'b1;           // a request during reset must not be granted
        bus.dbg_req  = 1'b1;
        repeat (3) step();
        chk("reset outputs", {16'd0, all_outs()}, 32'd0);
        chk("reset rdata", bus.host_rdata | bus.dbg_rdata, 32'd0);
        chk("reset tgt cmd", bus.tgt_addr | bus.tgt_wdata, 32'd0);
        bus.host_req = 1'b0;
        bus.dbg_req  = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();

        // Target activity while idle must be ignored.
        bad = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.tgt_ack = 1'b1; bus.tgt_err = 1'b1; bus.tgt_rdata = $urandom;
            step();
            bad |= (all_outs() !== 16'd0);
        end
        bus.tgt_ack = 1'b0; bus.tgt_err = 1'b0;
        step();
        chk("idle ack ignored", {31'd0, bad}, 32'd0);

        for (int i = 0; i < 12; i++)
            run_txn(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a debug access: dropped silently, pointer back to "host last".
        v = '{1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,32'h0,32'h0000_0400,32'h0,0,32'h3141_5926,1'b0,
              ARB_OWN_DBG,32'h3141_5926,1'b0,1'b0};
        run_txn(v, "pre-reset");
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 32'h0000_0404;
        step();
        chk("mid-reset dbg_gnt", {31'd0, bus.dbg_gnt}, 32'd1);
        bus.dbg_req = 1'b0;
        step();
        step();
        chk("mid-reset tgt_req before", {31'd0, bus.tgt_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-reset outputs cleared", {16'd0, all_outs()}, 32'd0);
        reset_model();
        step();
        bus.tgt_ack = 1'b1; bus.tgt_rdata = 32'hFEED_BEEF;
        @(negedge clk) rst_n = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            bad |= bus.host_rsp_valid | bus.dbg_rsp_valid | bus.tgt_req | bus.host_gnt | bus.dbg_gnt;
        end
        bus.tgt_ack = 1'b0;
        chk("no response after reset", {31'd0, bad}, 32'd0);
        v = '{1'b1,1'b1,1'b0,1'b0,1'b0,32'h0000_0500,32'h0,32'h0000_0600,32'h0,2,32'h0A0B_0C0D,1'b0,
              ARB_OWN_DBG,32'h0A0B_0C0D,1'b0,1'b0};
        run_txn(v, "post-reset tie");

        // Randomized traffic against the arbitration/response rules.
        for (int i = 0; i < 40; i++) begin
            r        = $urandom_range(1, 3);
            v.hreq   = r[0];
            v.dreq   = r[1];
            v.halted = ($urandom_range(0, 3) == 0);
            v.hwe    = $urandom_range(0, 1) == 1;
            v.dwe    = $urandom_range(0, 1) == 1;
            v.haddr  = $urandom; v.hwd = $urandom;
            v.daddr  = $urandom; v.dwd = $urandom;
            v.delay  = $urandom_range(0, TO + 1);
            v.trd    = $urandom;
            v.terr   = ($urandom_range(0, 3) == 0);
            if (v.dreq && (!v.hreq || v.halted || last_m == ARB_OWN_HOST))
                v.exp_own = ARB_OWN_DBG;
            else
                v.exp_own = ARB_OWN_HOST;
            v.exp_to  = (v.delay >= TO);
            v.exp_err = v.exp_to ? 1'b1 : v.terr;
            if (v.exp_to || (v.exp_own == ARB_OWN_HOST ? v.hwe : v.dwe))
                v.exp_rd = 32'd0;
            else
                v.exp_rd = v.trd;
            run_txn(v, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
